// File: rtl/bch_dec_corr_buf_pkg.sv
// Shared definitions for the DEC BCH correction stage: status codes and helpers.
// Combinational helpers only; no state.
// No flow control of its own.
package bch_dec_corr_buf_pkg;

   // Widest data word the helpers below accept; narrower words are zero-extended.
   localparam int PK_MAX_W = 64;

   // Per-word outcome carried alongside the corrected data.
   typedef enum logic [1:0] {
      ST_CLEAN = 2'b00,
      ST_CORR1 = 2'b01,
      ST_CORR2 = 2'b10,
      ST_UNC   = 2'b11
   } st_t;

   // Bits needed to hold values 0..n-1 (at least 1).
   function automatic int fn_width(input int n);
      int w;
      w = 1;
      while ((1 << w) < n) w = w + 1;
      return w;
   endfunction

   // Number of set bits, clamped to 3: only 0, 1, 2 and "more" matter for a DEC code.
   function automatic logic [1:0] fn_popcnt2(input logic [PK_MAX_W-1:0] v);
      logic [1:0] c;
      c = 2'd0;
      for (int i = 0; i < PK_MAX_W; i++) begin
         if (v[i] && (c != 2'd3)) c = c + 2'd1;
      end
      return c;
   endfunction

endpackage

// File: rtl/bch_dec_corr_buf_classify.sv
// Applies the decoder's error mask and classifies the word (clean/1-bit/2-bit/uncorrectable).
// Purely combinational, zero latency.
// No backpressure; the caller decides when the result is consumed.
module bch_corr_classify
   import bch_dec_corr_buf_pkg::*;
#(
   parameter int P_D_WIDTH = 32
) (
   input  logic [P_D_WIDTH-1:0] d_i,
   input  logic [P_D_WIDTH-1:0] msk_i,
   input  logic                 err_det_i,
   output logic [P_D_WIDTH-1:0] d_o,
   output st_t                  st_o
);

   logic [1:0] w;

   assign w = fn_popcnt2(PK_MAX_W'(msk_i));

   // A mask of weight 1 or 2 is trusted; any other weight with a non-zero syndrome
   // means the decoder could not locate the errors, so the raw word passes through.
   always_comb begin
      d_o  = d_i;
      st_o = ST_CLEAN;
      if (err_det_i) begin
         case (w)
            2'd1: begin
               d_o  = d_i ^ msk_i;
               st_o = ST_CORR1;
            end
            2'd2: begin
               d_o  = d_i ^ msk_i;
               st_o = ST_CORR2;
            end
            default: st_o = ST_UNC;
         endcase
      end
   end

endmodule

// File: rtl/bch_dec_corr_buf.sv
// Corrects/classifies decoder output words, buffers them in a 2-entry FIFO, counts errors.
// One cycle from accepted input to vld_o; full throughput with rdy_i held high.
// rdy_o drops when both entries are occupied; it is a register decode, not a path from rdy_i.
module bch_dec_corr_buf
   import bch_dec_corr_buf_pkg::*;
#(
   parameter int P_D_WIDTH   = 32,
   parameter int P_CNT_WIDTH = 16
) (
   input  logic                   clk_i,
   input  logic                   rst_n_i,
   input  logic                   vld_i,
   output logic                   rdy_o,
   input  logic [P_D_WIDTH-1:0]   d_i,
   input  logic [P_D_WIDTH-1:0]   msk_i,
   input  logic                   err_det_i,
   output logic                   vld_o,
   input  logic                   rdy_i,
   output logic [P_D_WIDTH-1:0]   d_o,
   output logic [1:0]             err_st_o,
   input  logic                   clr_cnt_i,
   output logic [P_CNT_WIDTH-1:0] cnt_corr_o,
   output logic [P_CNT_WIDTH-1:0] cnt_unc_o
);

   logic [P_D_WIDTH-1:0] cls_d;
   st_t                  cls_st;

   logic [P_D_WIDTH-1:0] mem_d  [2];
   st_t                  mem_st [2];
   logic                 wr_ptr;
   logic                 rd_ptr;
   logic [1:0]           cnt;
   logic                 push;
   logic                 pop;

   bch_corr_classify #(
      .P_D_WIDTH (P_D_WIDTH)
   ) u_classify (
      .d_i       (d_i),
      .msk_i     (msk_i),
      .err_det_i (err_det_i),
      .d_o       (cls_d),
      .st_o      (cls_st)
   );

   assign rdy_o    = (cnt != 2'd2);
   assign vld_o    = (cnt != 2'd0);
   assign push     = vld_i & rdy_o;
   assign pop      = vld_o & rdy_i;
   assign d_o      = mem_d[rd_ptr];
   assign err_st_o = mem_st[rd_ptr];

   // FIFO storage, pointers and occupancy; 1-bit pointers wrap on their own.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         for (int i = 0; i < 2; i++) begin
            mem_d[i]  <= '0;
            mem_st[i] <= ST_CLEAN;
         end
         wr_ptr <= 1'b0;
         rd_ptr <= 1'b0;
         cnt    <= 2'd0;
      end else begin
         if (push) begin
            mem_d[wr_ptr]  <= cls_d;
            mem_st[wr_ptr] <= cls_st;
            wr_ptr         <= ~wr_ptr;
         end
         if (pop) rd_ptr <= ~rd_ptr;
         if (push && !pop)      cnt <= cnt + 2'd1;
         else if (pop && !push) cnt <= cnt - 2'd1;
      end
   end

   // Saturating statistics, counted at acceptance; clear wins over a same-cycle increment.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         cnt_corr_o <= '0;
         cnt_unc_o  <= '0;
      end else if (clr_cnt_i) begin
         cnt_corr_o <= '0;
         cnt_unc_o  <= '0;
      end else if (push) begin
         if ((cls_st == ST_CORR1 || cls_st == ST_CORR2) && (cnt_corr_o != '1))
            cnt_corr_o <= cnt_corr_o + P_CNT_WIDTH'(1);
         if ((cls_st == ST_UNC) && (cnt_unc_o != '1))
            cnt_unc_o <= cnt_unc_o + P_CNT_WIDTH'(1);
      end
   end

endmodule

// File: tb/tb_bch_dec_corr_buf.sv
module tb_bch_dec_corr_buf;

   localparam int DW = 32;
   localparam int CW = 4;
   localparam int CMAX = (1 << CW) - 1;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          vld_i, rdy_o, err_det_i, vld_o, rdy_i, clr_cnt_i;
   logic [DW-1:0] d_i, msk_i, d_o;
   logic [1:0]    err_st_o;
   logic [CW-1:0] cnt_corr_o, cnt_unc_o;

   bch_dec_corr_buf #(.P_D_WIDTH(DW), .P_CNT_WIDTH(CW)) dut (
      .clk_i      (clk),
      .rst_n_i    (rst_n),
      .vld_i      (vld_i),
      .rdy_o      (rdy_o),
      .d_i        (d_i),
      .msk_i      (msk_i),
      .err_det_i  (err_det_i),
      .vld_o      (vld_o),
      .rdy_i      (rdy_i),
      .d_o        (d_o),
      .err_st_o   (err_st_o),
      .clr_cnt_i  (clr_cnt_i),
      .cnt_corr_o (cnt_corr_o),
      .cnt_unc_o  (cnt_unc_o)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [DW-1:0] d;
      logic [1:0]    st;
   } ent_t;

   typedef struct {
      logic [DW-1:0] d;
      logic [DW-1:0] msk;
      logic          det;
      logic [DW-1:0] exp_d;
      logic [1:0]    exp_st;
   } vec_t;

   int     n_cmp = 0;
   int     n_bad = 0;
   ent_t   mq[$];
   logic [DW-1:0] out_log[$];
   int     m_corr = 0;
   int     m_unc  = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Reference behaviour written straight from the classification rules.
   function automatic ent_t ref_cls(input logic [DW-1:0] d, input logic [DW-1:0] m, input logic det);
      ent_t e;
      int   w;
      w = $countones(m);
      e.d  = d;
      e.st = 2'd0;
      if (det) begin
         if (w == 1 || w == 2) begin
            e.d  = d ^ m;
            e.st = 2'(w);
         end else begin
            e.st = 2'd3;
         end
      end
      return e;
   endfunction

   // Compare current outputs to the model, then advance one clock and update the model.
   task automatic cycle();
      bit   push, pop;
      ent_t e;
      chk("rdy_o", 64'(rdy_o), 64'(mq.size() != 2));
      chk("vld_o", 64'(vld_o), 64'(mq.size() != 0));
      if (mq.size() != 0) begin
         chk("d_o", 64'(d_o), 64'(mq[0].d));
         chk("err_st_o", 64'(err_st_o), 64'(mq[0].st));
      end
      chk("cnt_corr_o", 64'(cnt_corr_o), 64'(m_corr));
      chk("cnt_unc_o", 64'(cnt_unc_o), 64'(m_unc));
      push = vld_i && (mq.size() != 2);
      pop  = rdy_i && (mq.size() != 0);
      e    = ref_cls(d_i, msk_i, err_det_i);
      @(posedge clk);
      #1;
      if (pop) begin
         out_log.push_back(mq[0].d);
         void'(mq.pop_front());
      end
      if (clr_cnt_i) begin
         m_corr = 0;
         m_unc  = 0;
      end else if (push) begin
         if ((e.st == 2'd1 || e.st == 2'd2) && m_corr < CMAX) m_corr++;
         if (e.st == 2'd3 && m_unc < CMAX) m_unc++;
      end
      if (push) mq.push_back(e);
   endtask

   task automatic drive(input logic v, input logic [DW-1:0] d, input logic [DW-1:0] m, input logic det);
      vld_i = v; d_i = d; msk_i = m; err_det_i = det;
   endtask

   vec_t tbl[5];

   initial begin
      logic [DW-1:0] m;
      logic [DW-1:0] held;
      int            k;

      rst_n = 1'b0; vld_i = 1'b0; rdy_i = 1'b0; clr_cnt_i = 1'b0;
      d_i = '0; msk_i = '0; err_det_i = 1'b0;
      #3;
      chk("rst vld_o", 64'(vld_o), 64'(0));
      chk("rst rdy_o", 64'(rdy_o), 64'(1));
      chk("rst d_o", 64'(d_o), 64'(0));
      chk("rst err_st_o", 64'(err_st_o), 64'(0));
      chk("rst cnt_corr", 64'(cnt_corr_o), 64'(0));
      chk("rst cnt_unc", 64'(cnt_unc_o), 64'(0));
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Directed vectors: each pushed into an empty buffer, visible the next cycle.
      tbl[0] = '{32'hDEADBEEF, 32'h00000010, 1'b0, 32'hDEADBEEF, 2'b00};
      tbl[1] = '{32'h00000001, 32'h00000001, 1'b1, 32'h00000000, 2'b01};
      tbl[2] = '{32'h80000001, 32'h80000001, 1'b1, 32'h00000000, 2'b10};
      tbl[3] = '{32'h12345678, 32'h00000000, 1'b1, 32'h12345678, 2'b11};
      tbl[4] = '{32'h12345678, 32'h00000007, 1'b1, 32'h12345678, 2'b11};
      rdy_i = 1'b1;
      for (int i = 0; i < 5; i++) begin
         drive(1'b1, tbl[i].d, tbl[i].msk, tbl[i].det);
         cycle();
         drive(1'b0, '0, '0, 1'b0);
         chk($sformatf("tbl%0d vld", i), 64'(vld_o), 64'(1));
         chk($sformatf("tbl%0d d", i), 64'(d_o), 64'(tbl[i].exp_d));
         chk($sformatf("tbl%0d st", i), 64'(err_st_o), 64'(tbl[i].exp_st));
         cycle();
      end
      chk("tbl cnt_corr", 64'(cnt_corr_o), 64'(2));
      chk("tbl cnt_unc", 64'(cnt_unc_o), 64'(2));

      // Backpressure: A and B fill the buffer, C must wait until space frees up.
      out_log.delete();
      rdy_i = 1'b0;
      drive(1'b1, 32'hAAAA0001, '0, 1'b0); cycle();
      drive(1'b1, 32'hBBBB0002, '0, 1'b0); cycle();
      drive(1'b1, 32'hCCCC0003, '0, 1'b0);
      chk("bp rdy_o low", 64'(rdy_o), 64'(0));
      held = d_o;
      cycle(); cycle();
      chk("bp head stable", 64'(d_o), 64'(held));
      chk("bp head is A", 64'(d_o), 64'(32'hAAAA0001));
      rdy_i = 1'b1;
      cycle();
      cycle();
      drive(1'b0, '0, '0, 1'b0);
      for (int i = 0; i < 3; i++) cycle();
      chk("bp out count", 64'(out_log.size()), 64'(3));
      if (out_log.size() == 3) begin
         chk("bp out A", 64'(out_log[0]), 64'(32'hAAAA0001));
         chk("bp out B", 64'(out_log[1]), 64'(32'hBBBB0002));
         chk("bp out C", 64'(out_log[2]), 64'(32'hCCCC0003));
      end

      // Randomised traffic against the model.
      for (int i = 0; i < 400; i++) begin
         k = $urandom_range(0, 4);
         m = '0;
         for (int j = 0; j < k; j++) m[$urandom_range(0, DW - 1)] = 1'b1;
         drive(1'($urandom_range(0, 3) != 0), $urandom, m, 1'($urandom_range(0, 3) != 0));
         rdy_i     = 1'($urandom_range(0, 2) != 0);
         clr_cnt_i = 1'($urandom_range(0, 30) == 0);
         cycle();
      end
      drive(1'b0, '0, '0, 1'b0);
      clr_cnt_i = 1'b0;
      rdy_i = 1'b1;
      cycle(); cycle(); cycle();

      // Saturation then clear racing an increment.
      for (int i = 0; i < 20; i++) begin
         drive(1'b1, 32'h00000001, 32'h00000001, 1'b1);
         cycle();
      end
      chk("sat cnt_corr", 64'(cnt_corr_o), 64'(CMAX));
      clr_cnt_i = 1'b1;
      cycle();
      clr_cnt_i = 1'b0;
      drive(1'b0, '0, '0, 1'b0);
      chk("clr cnt_corr", 64'(cnt_corr_o), 64'(0));
      chk("clr cnt_unc", 64'(cnt_unc_o), 64'(0));
      cycle(); cycle();

      // Asynchronous reset with two words buffered.
      rdy_i = 1'b0;
      drive(1'b1, 32'h11111111, 32'h1, 1'b1); cycle();
      drive(1'b1, 32'h22222222, 32'h0, 1'b1); cycle();
      drive(1'b0, '0, '0, 1'b0);
      chk("pre-rst vld_o", 64'(vld_o), 64'(1));
      chk("pre-rst rdy_o", 64'(rdy_o), 64'(0));
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst vld_o", 64'(vld_o), 64'(0));
      chk("arst rdy_o", 64'(rdy_o), 64'(1));
      chk("arst cnt_corr", 64'(cnt_corr_o), 64'(0));
      chk("arst cnt_unc", 64'(cnt_unc_o), 64'(0));
      chk("arst d_o", 64'(d_o), 64'(0));
      mq.delete();
      m_corr = 0;
      m_unc  = 0;
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      rdy_i = 1'b1;
      cycle(); cycle();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
